// File: rtl/branch_predictor.sv
// BTB + PHT next-fetch predictor with selectable bimodal or gshare indexing.
// Lookup is purely combinational; all learning and history updates land at the next rising edge.
module branch_predictor #(
  parameter  int ENTRIES  = 32,
  parameter  int CTR_BITS = 2,
  parameter  int GHR_BITS = 5,
  parameter  int MODE     = 0,
  localparam int IDX_W    = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         current_pc,
  input  logic                lookup_en,
  output logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [IDX_W-1:0]    pred_idx,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [31:0]         upd_target,
  input  logic                upd_taken,
  input  logic                upd_is_jump,
  input  logic                upd_mispredict,
  input  logic [IDX_W-1:0]    upd_idx,
  input  logic [GHR_BITS-1:0] upd_ghr
);

  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [ENTRIES-1:0]  btb_valid_q, btb_valid_d;
  logic [ENTRIES-1:0]  btb_jump_q, btb_jump_d;
  logic [TAG_W-1:0]    btb_tag_q    [ENTRIES];
  logic [TAG_W-1:0]    btb_tag_d    [ENTRIES];
  logic [31:0]         btb_target_q [ENTRIES];
  logic [31:0]         btb_target_d [ENTRIES];
  logic [CTR_BITS-1:0] pht_q        [ENTRIES];
  logic [CTR_BITS-1:0] pht_d        [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  logic [IDX_W-1:0] lk_btb_idx, lk_pht_idx, upd_btb_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, lk_is_jump, lk_ctr_taken;
  logic [GHR_BITS:0] spec_hist, upd_hist;
  logic             unused_ok;

  assign unused_ok = ^{current_pc[1:0], upd_pc[1:0]};

  // Lookup path: reads registered state only, so same-cycle updates are never bypassed.
  always_comb begin
    lk_btb_idx   = current_pc[IDX_W+1:2];
    lk_tag       = current_pc[31:IDX_W+2];
    lk_pht_idx   = (MODE == 1) ? (lk_btb_idx ^ IDX_W'(ghr_q)) : lk_btb_idx;
    lk_hit       = btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);
    lk_is_jump   = btb_jump_q[lk_btb_idx];
    lk_ctr_taken = pht_q[lk_pht_idx][CTR_BITS-1];
    pred_taken   = lk_hit && (lk_is_jump || lk_ctr_taken);
    pred_pc      = pred_taken ? btb_target_q[lk_btb_idx] : current_pc + 32'd4;
    pred_idx     = lk_pht_idx;
    pred_ghr     = ghr_q;
  end

  assign spec_hist = {ghr_q, pred_taken};
  assign upd_hist  = {upd_ghr, upd_taken};

  // A resolved mispredict repairs history and takes priority over speculative shifting.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid && upd_mispredict) begin
      ghr_d = upd_is_jump ? upd_ghr : upd_hist[GHR_BITS-1:0];
    end else if (lookup_en && lk_hit && !lk_is_jump) begin
      ghr_d = spec_hist[GHR_BITS-1:0];
    end
  end

  always_comb begin
    pht_d = pht_q;
    if (upd_valid && !upd_is_jump) begin
      if (upd_taken) begin
        if (pht_q[upd_idx] != CTR_MAX) pht_d[upd_idx] = pht_q[upd_idx] + CTR_BITS'(1);
      end else begin
        if (pht_q[upd_idx] != '0) pht_d[upd_idx] = pht_q[upd_idx] - CTR_BITS'(1);
      end
    end
  end

  // Only redirecting outcomes allocate; a not-taken branch leaves its BTB slot untouched.
  always_comb begin
    upd_btb_idx  = upd_pc[IDX_W+1:2];
    upd_tag      = upd_pc[31:IDX_W+2];
    btb_valid_d  = btb_valid_q;
    btb_jump_d   = btb_jump_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    if (upd_valid && (upd_taken || upd_is_jump)) begin
      btb_valid_d[upd_btb_idx]  = 1'b1;
      btb_jump_d[upd_btb_idx]   = upd_is_jump;
      btb_tag_d[upd_btb_idx]    = upd_tag;
      btb_target_d[upd_btb_idx] = upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ghr_q       <= '0;
      btb_valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= CTR_INIT;
    end else begin
      ghr_q       <= ghr_d;
      btb_valid_q <= btb_valid_d;
      pht_q       <= pht_d;
    end
  end

  // Payload fields are meaningless while their valid bit is clear, so they carry no reset.
  always_ff @(posedge clk) begin
    btb_jump_q   <= btb_jump_d;
    btb_tag_q    <= btb_tag_d;
    btb_target_q <= btb_target_d;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 32: BTB/PHT entry count, power of two, 4..1024; IDX_W = log2(ENTRIES).
REQ-002 SHALL have parameter CTR_BITS, default 2: saturating counter width, 1..4.
REQ-003 SHALL have parameter GHR_BITS, default 5: global history width, 1..IDX_W.
REQ-004 SHALL have parameter MODE, default 0: 0 = bimodal, 1 = gshare.
REQ-005 SHALL have one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous, active-low; state clears when 0 at posedge.
REQ-008 current_pc  in  32  IF-stage fetch address.
REQ-009 lookup_en  in  1  IF advances this cycle (pipeline not stalled).
REQ-010 pred_pc  out  32  predicted next fetch address.
REQ-011 pred_taken  out  1  prediction is redirect (taken branch or jump).
REQ-012 pred_idx  out  IDX_W  PHT index used; carried down pipeline.
REQ-013 pred_ghr  out  GHR_BITS  GHR snapshot at lookup; carried down pipeline.
REQ-014 upd_valid  in  1  resolved control-flow instruction in EX.
REQ-015 upd_pc / upd_target  in  32 each  resolved instruction address / actual target.
REQ-016 upd_taken, upd_is_jump, upd_mispredict  in  1 each  actual outcome, jal/jalr, redirect required.
REQ-017 upd_idx  in  IDX_W; upd_ghr  in  GHR_BITS  values returned from pred_idx/pred_ghr.

Function
REQ-018 Lookup SHALL be combinational, zero latency, from current_pc and registered state only.
REQ-019 BTB index SHALL be current_pc[IDX_W+1:2]; tag SHALL be current_pc[31:IDX_W+2]; entry = valid, tag, target[31:0], is_jump.
REQ-020 PHT index SHALL be current_pc[IDX_W+1:2] (MODE 0) or current_pc[IDX_W+1:2] XOR zero-extended GHR (MODE 1).
REQ-021 Hit SHALL be entry valid AND tag equal; counter taken = counter MSB.
REQ-022 pred_taken SHALL be hit AND (is_jump OR counter MSB); pred_pc SHALL be BTB target if pred_taken, else current_pc+4 (mod 2^32).
REQ-023 On lookup_en AND hit AND NOT is_jump, GHR SHALL shift left one bit inserting pred_taken at the next posedge.
REQ-024 On upd_valid AND upd_mispredict, GHR SHALL load {upd_ghr[GHR_BITS-2:0], upd_taken} for branches, upd_ghr for jumps; this SHALL override REQ-023 in the same cycle.
REQ-025 On upd_valid AND NOT upd_is_jump, PHT[upd_idx] SHALL increment if upd_taken else decrement, saturating at 2^CTR_BITS-1 and 0.
REQ-026 On upd_valid AND (upd_taken OR upd_is_jump), BTB[upd_pc index] SHALL be written valid, tag, upd_target, upd_is_jump; not-taken branches SHALL NOT allocate or invalidate.
REQ-027 Updates SHALL take effect at posedge; lookup in the same cycle to the same entry SHALL see pre-update values (no bypass).
REQ-028 Tag mismatch (aliasing) SHALL be a miss; a later update SHALL overwrite the aliased entry.
REQ-029 upd_* inputs SHALL be ignored when upd_valid=0; lookup_en SHALL not affect pred_* outputs.

Reset
REQ-030 With reset=0 at posedge: all BTB valid bits 0, all counters 2^(CTR_BITS-1)-1 (weakly not-taken), GHR 0; reset SHALL win over any concurrent update.
REQ-031 During and after reset until first allocation: pred_taken=0, pred_pc=current_pc+4, pred_ghr=0.
REQ-032 Reset asserted mid-operation SHALL discard all learned state within one cycle.

Verification
REQ-033 After reset, current_pc=0x100 -> pred_taken=0, pred_pc=0x104, pred_ghr=0.
REQ-034 Update pc=0x10, target=0x40, is_jump=1 -> next cycle current_pc=0x10 gives pred_pc=0x40, pred_taken=1; current_pc=0x10+4*ENTRIES misses, pred_pc=+4.
REQ-035 MODE 0, CTR_BITS 2, branch pc=0x20 target 0x80: two taken updates -> counter 3, predicts 0x80; three not-taken updates -> counter 0 (saturates), predicts 0x24; further decrement holds 0.
REQ-036 MODE 1: GHR=0b00101, upd_mispredict=1, upd_taken=1, upd_ghr=0b00011 with simultaneous speculative hit -> GHR=0b00111 next cycle.
REQ-037 Update and lookup same entry same cycle -> lookup shows old prediction, new one next cycle.
REQ-038 Reset pulse after training -> REQ-033 response on previously trained PCs.
